// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the register file: two valid/ready writeback requesters plus a bulk clear.
// Define RR_ARB_EN for round-robin contention handling; default build uses fixed priority (req0 wins).
module regfile_write_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_reg,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_reg,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              clear_done,
  output logic [ADDR_W-1:0] rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_write_enable
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t state_reg;
  logic   grant0;
  logic   grant1;

`ifdef RR_ARB_EN
  // 1 means req1 is favoured on the next contention
  logic rr_ptr_reg;
`endif

  // A grant implies the matching valid, so a grant is a completed transfer.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_reg == IDLE && !clear_start && !reset) begin
`ifdef RR_ARB_EN
      if (req0_valid && req1_valid) begin
        grant0 = !rr_ptr_reg;
        grant1 = rr_ptr_reg;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
`else
      grant0 = req0_valid;
      grant1 = req1_valid && !req0_valid;
`endif
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= IDLE;
      rf_write_enable <= 1'b0;
      rf_write_reg    <= '0;
      rf_write_data   <= '0;
      clear_busy      <= 1'b0;
      clear_done      <= 1'b0;
`ifdef RR_ARB_EN
      rr_ptr_reg      <= 1'b0;
`endif
    end else begin
      clear_done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (clear_start) begin
            // First clear write (index 1) is issued straight from the entry edge
            state_reg       <= CLEAR;
            clear_busy      <= 1'b1;
            rf_write_enable <= 1'b1;
            rf_write_reg    <= ADDR_W'(1);
            rf_write_data   <= '0;
          end else if (grant0) begin
            rf_write_enable <= (req0_reg != '0);
            rf_write_reg    <= req0_reg;
            rf_write_data   <= req0_data;
`ifdef RR_ARB_EN
            rr_ptr_reg      <= 1'b1;
`endif
          end else if (grant1) begin
            rf_write_enable <= (req1_reg != '0);
            rf_write_reg    <= req1_reg;
            rf_write_data   <= req1_data;
`ifdef RR_ARB_EN
            rr_ptr_reg      <= 1'b0;
`endif
          end else begin
            rf_write_enable <= 1'b0;
          end
        end
        CLEAR: begin
          // The output index register doubles as the clear walker
          if (rf_write_reg == LAST_IDX) begin
            state_reg       <= IDLE;
            clear_busy      <= 1'b0;
            clear_done      <= 1'b1;
            rf_write_enable <= 1'b0;
          end else begin
            rf_write_reg    <= rf_write_reg + ADDR_W'(1);
            rf_write_enable <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter; expectations follow RR_ARB_EN when defined.
module tb_regfile_write_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_reg, req1_reg;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        clear_start, clear_busy, clear_done;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;
  logic        rf_write_enable;

  int total = 0;
  int bad   = 0;

  regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_reg(req0_reg), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_reg(req1_reg), .req1_data(req1_data), .req1_ready(req1_ready),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
    .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data), .rf_write_enable(rf_write_enable)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic exp0;
    int   writes;
    int   dones;
    int   found;

    reset = 1'b1; clear_start = 1'b0;
    req0_valid = 1'b0; req0_reg = '0; req0_data = '0;
    req1_valid = 1'b0; req1_reg = '0; req1_data = '0;
    tick(); tick();
    check("rst_we",    32'(rf_write_enable), 0);
    check("rst_reg",   32'(rf_write_reg), 0);
    check("rst_data",  rf_write_data, 0);
    check("rst_busy",  32'(clear_busy), 0);
    check("rst_done",  32'(clear_done), 0);
    check("rst_rdy0",  32'(req0_ready), 0);
    check("rst_rdy1",  32'(req1_ready), 0);
    reset = 1'b0;
    tick();

    // 1: req0 alone
    req0_valid = 1'b1; req0_reg = 5'd1; req0_data = 32'hAABBCCDD;
    #1;
    check("t1_rdy0", 32'(req0_ready), 1);
    check("t1_rdy1", 32'(req1_ready), 0);
    tick();
    req0_valid = 1'b0;
    check("t1_we",   32'(rf_write_enable), 1);
    check("t1_reg",  32'(rf_write_reg), 1);
    check("t1_data", rf_write_data, 32'hAABBCCDD);
    tick();
    check("idle_we",   32'(rf_write_enable), 0);
    check("idle_hold", 32'(rf_write_reg), 1);

    // 3: req1 to index 0 is accepted but does not write
    req1_valid = 1'b1; req1_reg = 5'd0; req1_data = 32'hDEADBEEF;
    #1;
    check("t3_rdy1", 32'(req1_ready), 1);
    check("t3_rdy0", 32'(req0_ready), 0);
    tick();
    req1_valid = 1'b0;
    check("t3_we", 32'(rf_write_enable), 0);

    // 2: contention for four cycles
    req0_valid = 1'b1; req0_reg = 5'd2; req0_data = 32'h12345678;
    req1_valid = 1'b1; req1_reg = 5'd3; req1_data = 32'hCAFEF00D;
    for (int i = 0; i < 4; i++) begin
`ifdef RR_ARB_EN
      exp0 = (i % 2 == 0);
`else
      exp0 = 1'b1;
`endif
      #1;
      check($sformatf("t2_rdy0_%0d", i), 32'(req0_ready), 32'(exp0));
      check($sformatf("t2_rdy1_%0d", i), 32'(req1_ready), 32'(!exp0));
      tick();
      check($sformatf("t2_we_%0d", i),   32'(rf_write_enable), 1);
      check($sformatf("t2_reg_%0d", i),  32'(rf_write_reg), exp0 ? 2 : 3);
      check($sformatf("t2_data_%0d", i), rf_write_data, exp0 ? 32'h12345678 : 32'hCAFEF00D);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    // 4: clear wins over a pending req0
    req0_valid = 1'b1; req0_reg = 5'd5; req0_data = 32'h55;
    clear_start = 1'b1;
    #1;
    check("t4_rdy0_start", 32'(req0_ready), 0);
    tick();
    clear_start = 1'b0;
    check("t4_busy_first", 32'(clear_busy), 1);
    for (int k = 1; k <= 31; k++) begin
      if (rf_write_enable !== 1'b1 || rf_write_reg !== 5'(k) || rf_write_data !== 32'h0 ||
          clear_done !== 1'b0 || req0_ready !== 1'b0)
        check($sformatf("t4_step_%0d", k), {rf_write_enable, clear_done, req0_ready, rf_write_reg},
              {1'b1, 1'b0, 1'b0, 5'(k)});
      tick();
    end
    check("t4_walk_reg", 32'(rf_write_reg), 31);
    check("t4_done", 32'(clear_done), 1);
    check("t4_busy", 32'(clear_busy), 0);
    check("t4_we",   32'(rf_write_enable), 0);
    check("t4_rdy0", 32'(req0_ready), 1);
    tick();
    req0_valid = 1'b0;
    check("t4_done_pulse", 32'(clear_done), 0);
    check("t4_acc_we",     32'(rf_write_enable), 1);
    check("t4_acc_reg",    32'(rf_write_reg), 5);
    check("t4_acc_data",   rf_write_data, 32'h55);
    tick();

    // 6: second clear_start during CLEAR is ignored
    clear_start = 1'b1;
    tick();
    writes = 0; dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (rf_write_enable) writes++;
      if (clear_done) dones++;
      clear_start = (i == 5);
      tick();
    end
    clear_start = 1'b0;
    check("t6_writes", 32'(writes), 31);
    check("t6_dones",  32'(dones), 1);

    // 5: reset at clear index 10
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      if (clear_busy && rf_write_reg == 5'd10) found = 1;
      else tick();
    end
    check("t5_reach10", 32'(found), 1);
    reset = 1'b1;
    tick();
    check("t5_we",   32'(rf_write_enable), 0);
    check("t5_reg",  32'(rf_write_reg), 0);
    check("t5_data", rf_write_data, 0);
    check("t5_busy", 32'(clear_busy), 0);
    check("t5_done", 32'(clear_done), 0);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (clear_done) dones++;
    end
    check("t5_no_done", 32'(dones), 0);
    req0_valid = 1'b1; req0_reg = 5'd7; req0_data = 32'h0BADF00D;
    #1;
    check("t5_rdy0", 32'(req0_ready), 1);
    tick();
    req0_valid = 1'b0;
    check("t5_acc_we",   32'(rf_write_enable), 1);
    check("t5_acc_reg",  32'(rf_write_reg), 7);
    check("t5_acc_data", rf_write_data, 32'h0BADF00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
